// File: rtl/pix_packer.sv
// pix_packer: packs a raster 8-bit pixel stream 4-per-word into memory, then kicks the accelerator and waits for it.
// Ports: clk, reset (async, active-low); start; pix_in/pix_valid/pix_ready handshake;
// addr/dataW/en/we memory write port; acc_start pulse / acc_finish level; finish.
// Optional PIX_PACKER_SOFCHK_EN adds sof input and sticky frame_err output.
module pix_packer #(
  parameter int WORDS_PER_ROW = 88,
  parameter int ROWS = 288,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [15:0] addr,
  output logic [31:0] dataW,
  output logic        en,
  output logic        we,
  output logic        acc_start,
  input  logic        acc_finish,
  output logic        finish
`ifdef PIX_PACKER_SOFCHK_EN
  ,
  input  logic        sof,
  output logic        frame_err
`endif
);
  localparam logic [14:0] LAST_WORD = 15'(WORDS_PER_ROW * ROWS - 1);
  typedef enum logic [2:0] {IDLE, FILL, FLUSH, KICK, WAIT, DONE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [14:0] cnt_q, cnt_d, waddr_q, waddr_d;
  logic [23:0] pbuf_q, pbuf_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
`ifdef PIX_PACKER_SOFCHK_EN
  logic        err_q, err_d;
  assign frame_err = err_q;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      waddr_q <= '0;
      pbuf_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
`ifdef PIX_PACKER_SOFCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      pbuf_q  <= pbuf_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
`ifdef PIX_PACKER_SOFCHK_EN
      err_q   <= err_d;
`endif
    end
  // wr_q marks the one-cycle write slot following completion of a word; it is
  // the only source of memory requests, so en/we stay low outside that slot.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    pbuf_d  = pbuf_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
`ifdef PIX_PACKER_SOFCHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = FILL;
        idx_d   = '0;
        cnt_d   = '0;
        pbuf_d  = '0;
`ifdef PIX_PACKER_SOFCHK_EN
        err_d   = 1'b0;
`endif
      end
      FILL: if (pix_valid) begin
`ifdef PIX_PACKER_SOFCHK_EN
        if (sof && (cnt_q != '0 || idx_q != '0)) begin
          pbuf_d = {16'h0, pix_in};
          idx_d  = 2'd1;
          cnt_d  = '0;
          err_d  = 1'b1;
        end else
`endif
        if (idx_q == 2'd3) begin
          wdata_d = {pix_in, pbuf_q};
          waddr_d = cnt_q;
          wr_d    = 1'b1;
          cnt_d   = cnt_q + 15'd1;
          idx_d   = '0;
          state_d = cnt_q == LAST_WORD ? FLUSH : FILL;
        end else begin
          pbuf_d[8*idx_q +: 8] = pix_in;
          idx_d = idx_q + 2'd1;
        end
      end
      FLUSH:   state_d = KICK;
      KICK:    state_d = WAIT;
      WAIT:    state_d = acc_finish ? DONE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  assign pix_ready = state_q == FILL;
  assign en        = wr_q;
  assign we        = wr_q;
  assign addr      = wr_q ? 16'(BASE_ADDR) + {1'b0, waddr_q} : '0;
  assign dataW     = wr_q ? wdata_q : '0;
  assign acc_start = state_q == KICK;
  assign finish    = state_q == DONE;
endmodule

// File: tb/tb_pix_packer.sv
// tb_pix_packer: randomized/directed bench for pix_packer against a queue-based frame model.
module tb_pix_packer;
  localparam int WPR = 4;
  localparam int NROWS = 2;
  localparam int BASE = 0;
  localparam int FW = WPR * NROWS;
  localparam int FP = FW * 4;
  logic clk = 1'b0;
  logic reset, start, pix_valid, acc_finish;
  logic [7:0] pix_in;
  logic pix_ready, en, we, acc_start, finish;
  logic [15:0] addr;
  logic [31:0] dataW;
`ifdef PIX_PACKER_SOFCHK_EN
  logic sof, frame_err;
`endif
  int vectors = 0;
  int miscompares = 0;
  int mode = 0;
  int k = 0;
  bit wr_next = 0;
  bit err = 0;
  logic [15:0] exp_addr;
  logic [31:0] exp_data;
  logic [7:0] wb[$];
  always #5 clk = ~clk;
  pix_packer #(.WORDS_PER_ROW(WPR), .ROWS(NROWS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .addr(addr), .dataW(dataW), .en(en), .we(we),
    .acc_start(acc_start), .acc_finish(acc_finish), .finish(finish)
`ifdef PIX_PACKER_SOFCHK_EN
    , .sof(sof), .frame_err(frame_err)
`endif
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic chk_all();
    check("pix_ready", 32'(pix_ready), 32'(mode == 1));
    check("en", 32'(en), 32'(wr_next));
    check("we", 32'(we), 32'(wr_next));
    check("addr", 32'(addr), wr_next ? 32'(exp_addr) : 32'h0);
    check("dataW", dataW, wr_next ? exp_data : 32'h0);
    check("acc_start", 32'(acc_start), 32'(mode == 3));
    check("finish", 32'(finish), 32'(mode == 5));
`ifdef PIX_PACKER_SOFCHK_EN
    check("frame_err", 32'(frame_err), 32'(err));
`endif
  endtask
  task automatic model_reset();
    mode = 0; k = 0; wr_next = 0; err = 0; wb.delete();
  endtask
  task automatic tick();
    bit restart;
    wr_next = 0;
    if (!reset) model_reset();
    else case (mode)
      0, 5: if (start) begin mode = 1; k = 0; err = 0; wb.delete(); end
      1: if (pix_valid) begin
`ifdef PIX_PACKER_SOFCHK_EN
        restart = sof && (k != 0 || wb.size() != 0);
`else
        restart = 0;
`endif
        if (restart) begin
          wb.delete(); wb.push_back(pix_in); k = 0; err = 1;
        end else begin
          wb.push_back(pix_in);
          if (wb.size() == 4) begin
            wr_next = 1;
            exp_addr = 16'(BASE + k);
            exp_data = {wb[3], wb[2], wb[1], wb[0]};
            wb.delete();
            if (k == FW - 1) mode = 2;
            k++;
          end
        end
      end
      2: mode = 3;
      3: mode = 4;
      4: if (acc_finish) mode = 5;
      default: mode = 0;
    endcase
    @(posedge clk);
    #1;
    chk_all();
  endtask
  task automatic start_frame();
    start = 1; tick(); start = 0;
  endtask
  task automatic finish_frame(input int wait_cycles);
    for (int n = 0; n < 10 && mode != 4; n++) tick();
    check("reach_wait", 32'(mode), 32'd4);
    acc_finish = 0;
    repeat (wait_cycles) tick();
    acc_finish = 1; tick(); acc_finish = 0;
    repeat (3) tick();
  endtask
  initial begin
    reset = 1; start = 0; pix_valid = 0; pix_in = 0; acc_finish = 0;
`ifdef PIX_PACKER_SOFCHK_EN
    sof = 0;
`endif
    #2 reset = 0;
    #1 model_reset();
    chk_all();
    repeat (3) tick();
    reset = 1;
    repeat (2) tick();
    // frame 1: continuous stream, value = index mod 256, valid left high past the end
    start_frame();
    for (int i = 0; i < FP; i++) begin
      pix_valid = 1; pix_in = 8'(i); tick();
    end
    pix_in = 8'h5A;
    finish_frame(50);
    pix_valid = 0;
    // frame 2: random valid gaps, random data, stray start/acc_finish during fill
    start_frame();
    for (int n = 0; n < 20 * FP && mode == 1; n++) begin
      pix_valid = 1'($urandom); pix_in = 8'($urandom);
      start = 1'($urandom); acc_finish = 1'($urandom);
      tick();
    end
    check("frame2_done_fill", 32'(mode == 1), 32'd0);
    start = 0; pix_valid = 0;
    finish_frame($urandom_range(1, 8));
    // frame 3: asynchronous reset after 6 pixels, then a fresh 0xAA word
    start_frame();
    for (int i = 0; i < 6; i++) begin
      pix_valid = 1; pix_in = 8'(i + 1); tick();
    end
    pix_valid = 0;
    reset = 0;
    #1 model_reset();
    chk_all();
    repeat (2) tick();
    reset = 1;
    tick();
    start_frame();
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1; pix_in = 8'hAA; tick();
    end
    pix_valid = 0;
    repeat (4) tick();
`ifdef PIX_PACKER_SOFCHK_EN
    // frame 4: sof on pixel 9 restarts the frame; later start clears frame_err
    reset = 0;
    #1 model_reset();
    reset = 1;
    start_frame();
    for (int i = 0; i < 13; i++) begin
      pix_valid = 1; pix_in = 8'(8'h40 + i); sof = (i == 9); tick();
    end
    sof = 0;
    check("sof_err", 32'(frame_err), 32'd1);
    for (int n = 0; n < 4 * FP && mode == 1; n++) begin
      pix_valid = 1; pix_in = 8'($urandom); tick();
    end
    pix_valid = 0;
    finish_frame(3);
    start_frame();
    pix_valid = 0;
    repeat (2) tick();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pix_packer.md
# pix_packer

Upstream loader for the edge-detection accelerator. Accepts a raster-order 8-bit grayscale pixel stream over a valid/ready handshake and packs 4 pixels per 32-bit word. Writes the frame into the shared data memory's source region (words BASE_ADDR..BASE_ADDR+25343). Then pulses the accelerator's start, waits for its finish, and reports frame completion.

## Interface
- WORDS_PER_ROW, 88, packed words per image row (352 pixels)
- ROWS, 288, image rows
- BASE_ADDR, 0, word address of pixel 0 in memory
- clk  in  1  the clock; all state on its rising edge
- reset  in  1  one clock; reset is asynchronous and active-low
- start  in  1  begin a new frame load (level sampled in IDLE/DONE)
- pix_in  in  8  grayscale pixel
- pix_valid  in  1  pix_in valid this cycle
- pix_ready  out  1  block accepts pix_in this cycle
- addr  out  16  memory word address
- dataW  out  32  memory write data
- en  out  1  memory request
- we  out  1  memory write enable
- acc_start  out  1  one-cycle start pulse to accelerator
- acc_finish  in  1  accelerator finished (level)
- finish  out  1  frame loaded and processed

## Operation
- States: IDLE, FILL, FLUSH, KICK, WAIT, DONE.
- IDLE: pix_ready=0. start=1 -> FILL; clear byte index (0..3), word counter, pixel buffer.
- FILL: pix_ready=1. Each accepted pixel (pix_valid&pix_ready) goes to byte lane idx: pixel 4k+j -> dataW[8j+7:8j] of word k (leftmost pixel in LSBs).
  - On acceptance with idx=3, the complete word is latched and a write is scheduled for the next cycle. idx wraps to 0.
  - The write cycle drives en=1, we=1, addr=BASE_ADDR+k, dataW=word. Pixel acceptance continues in parallel with it.
  - After the write of word FRAME_WORDS-1 is scheduled (FRAME_WORDS = WORDS_PER_ROW*ROWS = 25344), the next state is FLUSH.
- FLUSH: pix_ready=0. Issues the final write -> KICK.
- KICK: acc_start=1 for exactly one cycle -> WAIT.
- WAIT: en=we=0. acc_finish=1 -> DONE.
- DONE: finish=1, held. start=1 -> FILL with counters cleared (restart).
- Word counter is 15 bits, compared for equality with FRAME_WORDS-1. addr = BASE_ADDR + counter, truncated to 16 bits.
- pix_valid with pix_ready=0 has no effect. A start level outside IDLE/DONE is ignored.
- Outputs not named active in a state are 0 (addr, dataW = 0).

## Timing
- Reset values: pix_ready=0, addr=0, dataW=0, en=0, we=0, acc_start=0, finish=0. State IDLE; partial word discarded.
- Reset mid-frame: return to IDLE immediately (asynchronous). No further memory writes occur. Memory contents already written are not cleared.
- Start latency: start sampled high in IDLE -> pix_ready=1 on the following cycle.
- Write latency: the 4th pixel of a word is accepted in cycle t -> en=we=1 with that word in cycle t+1.
- Throughput: 1 pixel/cycle sustained. pix_ready never drops inside FILL.
- Last pixel (#101375) accepted in cycle t:
  - t+1: FLUSH write of word 25343.
  - t+2: acc_start=1.
  - t+3 onward: WAIT.
- acc_finish high in cycle u (in WAIT) -> finish=1 from u+1.
- acc_finish high outside WAIT is ignored.

## Configuration
- PIX_PACKER_SOFCHK_EN defined:
  - Adds input sof (1 bit, qualifies pix_in) and output frame_err (1 bit, reset 0).
  - In FILL, an accepted pixel with sof=1 while (word counter, idx) != (0,0) aborts the partial frame. The pixel is stored as pixel 0 of word 0, counters restart, and frame_err is set sticky.
  - frame_err clears only on reset or on start in IDLE/DONE.
  - In IDLE, start plus sof are not required together.
- Not defined: no sof/frame_err ports. The frame is purely count-delimited.

## Test plan
- Reset, then start, then stream pixels 0x00,0x01,0x02,0x03 -> cycle after 4th acceptance: en=we=1, addr=0x0000, dataW=0x03020100.
- Full frame of 101376 pixels, value = index mod 256, valid always high -> 25344 writes to addr 0..25343. acc_start is high exactly 2 cycles after the last acceptance, then pix_ready=0.
- pix_valid toggling 1/0 across a word -> identical words and addresses to the continuous case. No write occurs until the 4th accepted pixel.
- WAIT with acc_finish held 0 for 50 cycles, then 1 -> finish=0 throughout; finish=1 the cycle after; en never asserted in WAIT.
- Assert reset (low) after 6 pixels, release, start again, stream 0xAA x4 -> exactly one write of 0xAAAAAAAA at addr 0; the stale pixels 4,5 never appear.
- With PIX_PACKER_SOFCHK_EN: sof=1 on pixel 9 -> frame_err=1. The next write is addr 0 holding pixel 9 in dataW[7:0].
